// File: rtl/clint_pkg.sv
// clint_pkg: register map, port FSM states and byte-lane merge helper for the CLINT.
package clint_pkg;

    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    typedef enum logic {CLINT_IDLE, CLINT_RESP} clint_state_e;

    function automatic logic [31:0] clint_merge(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = strb[i] ? wdata[i*8 +: 8] : old[i*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/clint_prescaler.sv
// clint_prescaler: 16-bit down-counter producing a one-cycle tick every TICK_DIV clocks.
module clint_prescaler #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam logic [15:0] RELOAD = 16'(TICK_DIV - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        tick  = cnt_q == 16'd0;
        cnt_d = tick ? RELOAD : cnt_q - 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= RELOAD;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/clint.sv
// clint: mtime/mtimecmp/msip registers behind a single-outstanding request/response port,
// with registered timer and software interrupt outputs.
module clint
    import clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        timer_interrupt,
    output logic        software_interrupt
);

    clint_state_e state_q, state_d;
    logic [63:0]  mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic         msip_q, msip_d, tirq_q, sirq_q, err_q, err_d;
    logic [31:0]  rdata_q, rdata_d, rd_val;
    logic         tick, accept, wr, mapped;
    logic         sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;
    logic [15:0]  addr;

    clint_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    always_comb begin
        addr       = req_addr & 16'hFFFC;
        sel_msip   = addr == CLINT_MSIP;
        sel_cmp_lo = addr == CLINT_MTIMECMP_LO;
        sel_cmp_hi = addr == CLINT_MTIMECMP_HI;
        sel_mt_lo  = addr == CLINT_MTIME_LO;
        sel_mt_hi  = addr == CLINT_MTIME_HI;
        mapped     = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_mt_lo | sel_mt_hi;
        accept     = state_q == CLINT_IDLE && req_valid;
        wr         = accept && req_we;
        rd_val     = sel_msip   ? {31'd0, msip_q}    :
                     sel_cmp_lo ? mtimecmp_q[31:0]   :
                     sel_cmp_hi ? mtimecmp_q[63:32]  :
                     sel_mt_lo  ? mtime_q[31:0]      :
                     sel_mt_hi  ? mtime_q[63:32]     : 32'd0;
        state_d    = accept ? CLINT_RESP :
                     (state_q == CLINT_RESP && rsp_ready) ? CLINT_IDLE : state_q;
        rdata_d    = accept ? (req_we ? 32'd0 : rd_val) : rdata_q;
        err_d      = accept ? !mapped : err_q;
        msip_d     = (wr && sel_msip && req_wstrb[0]) ? req_wdata[0] : msip_q;
        mtimecmp_d = {(wr && sel_cmp_hi) ? clint_merge(mtimecmp_q[63:32], req_wdata, req_wstrb) : mtimecmp_q[63:32],
                      (wr && sel_cmp_lo) ? clint_merge(mtimecmp_q[31:0], req_wdata, req_wstrb) : mtimecmp_q[31:0]};
        // A write to either mtime half swallows the tick for the full 64-bit counter.
        mtime_d    = (wr && sel_mt_lo) ? {mtime_q[63:32], clint_merge(mtime_q[31:0], req_wdata, req_wstrb)} :
                     (wr && sel_mt_hi) ? {clint_merge(mtime_q[63:32], req_wdata, req_wstrb), mtime_q[31:0]} :
                     mtime_q + 64'(tick);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= CLINT_IDLE;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            tirq_q     <= 1'b0;
            sirq_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            tirq_q     <= mtime_q >= mtimecmp_q;
            sirq_q     <= msip_q;
        end
    end

    assign req_ready          = state_q == CLINT_IDLE;
    assign rsp_valid          = state_q == CLINT_RESP;
    assign rsp_rdata          = rdata_q;
    assign rsp_err            = err_q;
    assign timer_interrupt    = tirq_q;
    assign software_interrupt = sirq_q;

endmodule

// File: doc/clint.md
# clint

Core-local interruptor for the RV32 core. It holds a free-running 64-bit `mtime` counter, a 64-bit `mtimecmp` compare register and the `msip` software-interrupt bit, all memory-mapped on a single-outstanding request/response port. It drives `timer_interrupt` and `software_interrupt` directly into the CSR block, which gates them with `mie`/`mstatus` and raises `interrupted`.

## Interface
- `TICK_DIV`, default 1: `mtime` increments once every `TICK_DIV` clk cycles. Legal range is 1..65535.
- `clk` input 1: the single clock. All state is updated on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset. It is released synchronously by the SoC reset synchroniser.
- `req_valid` input 1: a bus request is present.
- `req_ready` output 1: the block accepts the request in this cycle.
- `req_we` input 1: 1 for a write, 0 for a read.
- `req_addr` input 16: byte offset, word-aligned. Bits [1:0] are ignored.
- `req_wdata` input 32: write data.
- `req_wstrb` input 4: byte-lane enables for a write.
- `rsp_valid` output 1: a response is pending.
- `rsp_ready` input 1: the consumer takes the response.
- `rsp_rdata` output 32: read data. It is 0 for writes.
- `rsp_err` output 1: the request hit an unmapped address.
- `timer_interrupt` output 1: level signal, asserted while `mtime >= mtimecmp` (unsigned compare).
- `software_interrupt` output 1: level signal, equal to `msip`.

## Operation
- Register map:
  - 0x0000: `msip`. Only bit 0 is writable. Other bits read as 0.
  - 0x4000: `mtimecmp[31:0]`.
  - 0x4004: `mtimecmp[63:32]`.
  - 0xBFF8: `mtime[31:0]`.
  - 0xBFFC: `mtime[63:32]`.
  - Any other offset: reads return 0 and writes are dropped. In both cases `rsp_err`=1.
- Writes honour `req_wstrb` per byte. `wstrb`=0 is a legal no-op write and returns `rsp_err`=0 if the address is mapped.
- Port FSM has two states:
  - IDLE: `req_ready`=1. If `req_valid`=1, the request is accepted. Read data is captured from the current register values, any write is committed on the same edge, and the FSM goes to RESP.
  - RESP: `req_ready`=0, `rsp_valid`=1. `rsp_rdata` and `rsp_err` are held stable. When `rsp_ready`=1, the FSM returns to IDLE.
  - No back-to-back acceptance: a new request is not accepted in the cycle the response retires.
- Prescaler:
  - A 16-bit down-counter generates the tick.
  - When `TICK_DIV`=1, a tick occurs every cycle.
  - When the counter reaches 0, it reloads with `TICK_DIV`-1 and `mtime` increments by 1.
  - `mtime` wraps from 2^64-1 to 0 without any flag.
- A 64-bit read is not atomic. Software uses the hi-lo-hi sequence.

## Timing
- Reset values:
  - `mtime`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, `msip`=0, prescaler=`TICK_DIV`-1.
  - FSM in IDLE, so `req_ready`=1.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `timer_interrupt`=0, `software_interrupt`=0.
- Access latency: `rsp_valid` rises 1 cycle after acceptance.
- Interrupt outputs are registered:
  - `timer_interrupt` reflects the compare of the `mtime`/`mtimecmp` values present in the previous cycle. It rises 1 cycle after `mtime` first equals `mtimecmp`.
  - `software_interrupt` follows a `msip` write with the same 1-cycle delay.
- Write to an `mtime` half in the same cycle as a tick:
  - The written bytes take the write value.
  - That tick's increment is dropped for the whole 64-bit counter, including any carry into the other half.
  - The prescaler continues counting normally.
- Writing `mtimecmp` to a value above `mtime` deasserts `timer_interrupt` 1 cycle after the write edge.
- Writing `mtimecmp` halves one at a time may glitch the interrupt. This is acceptable; software is expected to write hi=all-ones first.
- Assertion of `reset_n` mid-transaction immediately drops `rsp_valid` and returns the FSM to IDLE. A pending response is lost.
- If `rsp_ready` is held low indefinitely, `mtime` keeps counting while the port stalls.

## Structure
- Package `clint_pkg` holds:
  - Address constants: `CLINT_MSIP`, `CLINT_MTIMECMP_LO`, `CLINT_MTIMECMP_HI`, `CLINT_MTIME_LO`, `CLINT_MTIME_HI`.
  - The FSM state enum: `CLINT_IDLE`, `CLINT_RESP`.
- Sub-module `clint_prescaler` takes `clk`, `reset_n` and `TICK_DIV` and produces the 1-cycle `tick` pulse.
- The register file, port FSM and comparator stay in `clint`.

## Test plan
1. Reset with `TICK_DIV`=1, then idle 10 cycles → read 0xBFF8 returns a value in 10..12. `timer_interrupt`=0 and `rsp_err`=0.
2. Write 0x4004=0 and 0x4000=`mtime_lo`+20 → `timer_interrupt` rises exactly 1 cycle after `mtime` equals the compare value. Then write 0x4004=0xFFFFFFFF → the interrupt falls 1 cycle after the write.
3. Write 0x0000=0xFFFFFFFF → `software_interrupt`=1 and a read of 0x0000 returns 0x00000001. Then write 0 → it clears.
4. `TICK_DIV`=4: write `mtime` hi=0, lo=0xFFFFFFFF → after 4 cycles, lo=0 and hi=1. Repeat with the write landing on a tick cycle → the written value is held with no increment.
5. Read 0x1234 → `rsp_err`=1 and `rsp_rdata`=0. Hold `rsp_ready`=0 for 5 cycles → the response stays stable, `req_ready`=0, and a second request is not accepted until the cycle after retirement.
6. Assert `reset_n` while `rsp_valid`=1 → all outputs reach their reset values immediately, asynchronously, without waiting for a clk edge.
